// File: rtl/timer_pkg.sv
// Shared definitions for the timer control front end: register map, field indices, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_pkg;

    // Register addresses
    localparam logic [1:0] TMR_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_ADDR_CONST  = 2'd1;
    localparam logic [1:0] TMR_ADDR_STATUS = 2'd2;
    localparam logic [1:0] TMR_ADDR_COUNT  = 2'd3;

    // CTRL bit indices
    localparam int CTRL_RUN         = 0;
    localparam int CTRL_UP          = 1;
    localparam int CTRL_AUTO_RELOAD = 2;
    localparam int CTRL_IRQ_EN      = 3;

    // STATUS bit indices
    localparam int STAT_EXPIRED  = 0;
    localparam int STAT_CNT_LSB  = 8;
    localparam int STAT_CNT_CLR  = 31;

    // Which CTRL bits are actually stored; auto_reload only exists when the feature is built in
`ifdef TIMER_CTRL_AUTORELOAD_EN
    localparam logic [3:0] CTRL_MASK = 4'b1111;
`else
    localparam logic [3:0] CTRL_MASK = 4'b1011;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2,
        ST_RELOAD  = 2'd3
    } tmr_state_t;

endpackage

// File: rtl/timer_ctrl.sv
// Register front end driving an up/down timer: CTRL/CONST/STATUS/COUNT, alarm edge -> sticky status, irq, restart.
// Latency: register writes take effect at the write edge; start/load pulses appear the cycle after; reads are combinational.
// Backpressure: none, writes are always accepted. Optional auto-restart built in with TIMER_CTRL_AUTORELOAD_EN.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = 32   // must not exceed 32 (readback bus width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             alarm_in,
    output logic             timer_start,
    output logic             timer_load,
    output logic             timer_up,
    output logic [WIDTH-1:0] timing_const,
    output logic             irq
);

    tmr_state_t       state;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] const_r;
    logic             expired;
    logic [7:0]       exp_cnt;
    logic             alarm_q;
    logic             start_r;
    logic             load_r;

    logic wr_ctrl;
    logic wr_const;
    logic wr_status;
    logic alarm_rise;
    logic run_edge;

    assign wr_ctrl    = wr_en && (addr == TMR_ADDR_CTRL);
    assign wr_const   = wr_en && (addr == TMR_ADDR_CONST);
    assign wr_status  = wr_en && (addr == TMR_ADDR_STATUS);
    assign alarm_rise = alarm_in & ~alarm_q;
    // Only alarm edges seen while counting are meaningful; others are stale or belong to a stopped timer
    assign run_edge   = alarm_rise && (state == ST_RUN);

    // Registers, alarm edge history, FSM and registered start/load pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ctrl    <= '0;
            const_r <= '0;
            expired <= 1'b0;
            exp_cnt <= '0;
            alarm_q <= 1'b0;
            start_r <= 1'b0;
            load_r  <= 1'b0;
        end else begin
            start_r <= 1'b0;
            load_r  <= 1'b0;
            alarm_q <= alarm_in;

            // Status clears first so a coincident alarm edge overrides them
            if (wr_status) begin
                if (wdata[STAT_EXPIRED]) expired <= 1'b0;
                if (wdata[STAT_CNT_CLR]) exp_cnt <= '0;
            end
            if (run_edge) begin
                expired <= 1'b1;
                if (exp_cnt != 8'hFF) exp_cnt <= exp_cnt + 8'd1;
            end

            // Reloading the constant mid-count tells the timer to pick it up immediately
            if (wr_const) begin
                const_r <= wdata[WIDTH-1:0];
                if (state == ST_RUN) load_r <= 1'b1;
            end

            // A CTRL write overrides whatever the alarm would have done to the state
            if (wr_ctrl) begin
                ctrl <= wdata[3:0] & CTRL_MASK;
                if (wdata[CTRL_RUN]) begin
                    state   <= ST_RUN;
                    start_r <= 1'b1;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (alarm_rise) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
                            state <= ctrl[CTRL_AUTO_RELOAD] ? ST_RELOAD : ST_EXPIRED;
`else
                            state <= ST_EXPIRED;
`endif
                        end
                    end
`ifdef TIMER_CTRL_AUTORELOAD_EN
                    ST_RELOAD: begin
                        state   <= ST_RUN;
                        start_r <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Combinational register readback
    always_comb begin
        rdata = '0;
        case (addr)
            TMR_ADDR_CTRL:   rdata = 32'(ctrl);
            TMR_ADDR_CONST:  rdata = 32'(const_r);
            TMR_ADDR_STATUS: begin
                rdata[STAT_EXPIRED]                 = expired;
                rdata[STAT_CNT_LSB +: 8]            = exp_cnt;
            end
            default:         rdata = 32'(cnt_in);
        endcase
    end

    assign timer_start  = start_r;
    assign timer_load   = load_r;
    assign timer_up     = ctrl[CTRL_UP];
    assign timing_const = const_r;
    assign irq          = expired & ctrl[CTRL_IRQ_EN];

endmodule
